// File: rtl/shuffle_ctrl.sv
// shuffle_ctrl: issues load shuffle-info commands and retires requests in order once every lane has taken all beats
module shuffle_ctrl #(
    parameter int unsigned NrLanes   = 4,
    parameter int unsigned MaxBeats  = 64,
    parameter int unsigned OutstDep  = 4,
    parameter int unsigned ReqIdBits = 4,
    parameter int unsigned SetBits   = 6,
    parameter int unsigned OffBits   = 2,
    localparam int unsigned BW = $clog2(MaxBeats) + 1,
    localparam int unsigned CW = $clog2(MaxBeats)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [ReqIdBits-1:0] req_id_i,
    input  logic [1:0]           req_mode_i,
    input  logic [1:0]           req_eew_i,
    input  logic [4:0]           req_vd_i,
    input  logic [15:0]          req_vstart_i,
    input  logic                 req_vm_i,
    input  logic [BW-1:0]        req_nr_beats_i,
    input  logic [SetBits-1:0]   req_vaddr_set_i,
    input  logic [OffBits-1:0]   req_vaddr_off_i,
    output logic                 shf_valid_o,
    input  logic                 shf_ready_i,
    output logic [ReqIdBits-1:0] shf_req_id_o,
    output logic [1:0]           shf_mode_o,
    output logic [1:0]           shf_eew_o,
    output logic [4:0]           shf_vd_o,
    output logic [15:0]          shf_vstart_o,
    output logic                 shf_vm_o,
    output logic [SetBits-1:0]   shf_vaddr_set_o,
    output logic [OffBits-1:0]   shf_vaddr_off_o,
    output logic [CW-1:0]        shf_cmt_cnt_o,
    input  logic [NrLanes-1:0]   lane_fire_i,
    output logic                 done_valid_o,
    input  logic                 done_ready_i,
    output logic [ReqIdBits-1:0] done_req_id_o,
    output logic                 busy_o
);
    localparam int unsigned PW = $clog2(OutstDep);
    localparam int unsigned LW = $clog2(OutstDep * MaxBeats) + 1;

    logic [PW:0]           wr_ptr, rd_ptr;
    logic [ReqIdBits-1:0]  oq_id [OutstDep];
    logic [BW-1:0]         oq_nb [OutstDep];
    logic [LW-1:0]         lane_cnt [NrLanes];
    logic [LW-1:0]         oq_sum;
    logic [BW-1:0]         head_nb;
    logic                  oq_empty, oq_full, req_fire, lanes_ok, cmpl;

    assign oq_empty    = wr_ptr == rd_ptr;
    assign oq_full     = wr_ptr == {~rd_ptr[PW], rd_ptr[PW-1:0]};
    assign head_nb     = oq_nb[rd_ptr[PW-1:0]];
    assign req_ready_o = !oq_full && (!shf_valid_o || shf_ready_i);
    assign req_fire    = req_valid_i && req_ready_o;
    assign cmpl        = !oq_empty && lanes_ok && (!done_valid_o || done_ready_i);
    assign busy_o      = !oq_empty || shf_valid_o || done_valid_o;

    always_comb begin
        lanes_ok = 1'b1;
        for (int l = 0; l < NrLanes; l++) lanes_ok &= lane_cnt[l] >= LW'(head_nb);
    end

    always_ff @(posedge clk_i) begin
        if (req_fire) begin
            oq_id[wr_ptr[PW-1:0]] <= req_id_i;
            oq_nb[wr_ptr[PW-1:0]] <= req_nr_beats_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            oq_sum          <= '0;
            shf_valid_o     <= 1'b0;
            shf_req_id_o    <= '0;
            shf_mode_o      <= '0;
            shf_eew_o       <= '0;
            shf_vd_o        <= '0;
            shf_vstart_o    <= '0;
            shf_vm_o        <= 1'b0;
            shf_vaddr_set_o <= '0;
            shf_vaddr_off_o <= '0;
            shf_cmt_cnt_o   <= '0;
            done_valid_o    <= 1'b0;
            done_req_id_o   <= '0;
            for (int l = 0; l < NrLanes; l++) lane_cnt[l] <= '0;
        end else begin
            shf_valid_o  <= req_fire || (shf_valid_o && !shf_ready_i);
            done_valid_o <= cmpl || (done_valid_o && !done_ready_i);
            if (req_fire) begin
                wr_ptr          <= wr_ptr + (PW + 1)'(1);
                shf_req_id_o    <= req_id_i;
                shf_mode_o      <= req_mode_i;
                shf_eew_o       <= req_eew_i;
                shf_vd_o        <= req_vd_i;
                shf_vstart_o    <= req_vstart_i;
                shf_vm_o        <= req_vm_i;
                shf_vaddr_set_o <= req_vaddr_set_i;
                shf_vaddr_off_o <= req_vaddr_off_i;
                shf_cmt_cnt_o   <= CW'(req_nr_beats_i - BW'(1));
            end
            if (cmpl) begin
                rd_ptr        <= rd_ptr + (PW + 1)'(1);
                done_req_id_o <= oq_id[rd_ptr[PW-1:0]];
            end
            // beats taken this cycle and the retired head's share apply together so no beat is lost
            oq_sum <= oq_sum + (req_fire ? LW'(req_nr_beats_i) : '0) - (cmpl ? LW'(head_nb) : '0);
            for (int l = 0; l < NrLanes; l++)
                lane_cnt[l] <= lane_cnt[l] + LW'(lane_fire_i[l]) - (cmpl ? LW'(head_nb) : '0);
            assert (!(oq_empty && |lane_fire_i)) else $error("lane beat accepted with no outstanding request");
            if (req_fire)
                assert (req_nr_beats_i != '0 && req_nr_beats_i <= BW'(MaxBeats)) else $error("request beat count out of range");
            for (int l = 0; l < NrLanes; l++)
                assert (lane_cnt[l] <= oq_sum) else $error("lane counter ahead of outstanding beats");
        end
    end
endmodule

// File: tb/tb_shuffle_ctrl.sv
// tb_shuffle_ctrl: directed scoreboard bench for shuffle_ctrl
module tb_shuffle_ctrl;
    localparam int NrLanes = 4, MaxBeats = 64, OutstDep = 4, ReqIdBits = 4, SetBits = 6, OffBits = 2;
    localparam int BW = $clog2(MaxBeats) + 1, CW = $clog2(MaxBeats);

    logic clk_i = 1'b0, rst_i = 1'b1;
    logic req_valid_i = 1'b0, req_ready_o;
    logic [ReqIdBits-1:0] req_id_i = '0;
    logic [1:0] req_mode_i = '0, req_eew_i = '0;
    logic [4:0] req_vd_i = '0;
    logic [15:0] req_vstart_i = '0;
    logic req_vm_i = 1'b0;
    logic [BW-1:0] req_nr_beats_i = BW'(1);
    logic [SetBits-1:0] req_vaddr_set_i = '0;
    logic [OffBits-1:0] req_vaddr_off_i = '0;
    logic shf_valid_o, shf_ready_i = 1'b1;
    logic [ReqIdBits-1:0] shf_req_id_o;
    logic [1:0] shf_mode_o, shf_eew_o;
    logic [4:0] shf_vd_o;
    logic [15:0] shf_vstart_o;
    logic shf_vm_o;
    logic [SetBits-1:0] shf_vaddr_set_o;
    logic [OffBits-1:0] shf_vaddr_off_o;
    logic [CW-1:0] shf_cmt_cnt_o;
    logic [NrLanes-1:0] lane_fire_i = '0;
    logic done_valid_o, done_ready_i = 1'b1;
    logic [ReqIdBits-1:0] done_req_id_o;
    logic busy_o;

    int checks = 0, errors = 0;
    logic [ReqIdBits-1:0] exp_q [$];

    shuffle_ctrl #(.NrLanes(NrLanes), .MaxBeats(MaxBeats), .OutstDep(OutstDep),
                   .ReqIdBits(ReqIdBits), .SetBits(SetBits), .OffBits(OffBits)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_id_i(req_id_i),
        .req_mode_i(req_mode_i), .req_eew_i(req_eew_i), .req_vd_i(req_vd_i),
        .req_vstart_i(req_vstart_i), .req_vm_i(req_vm_i), .req_nr_beats_i(req_nr_beats_i),
        .req_vaddr_set_i(req_vaddr_set_i), .req_vaddr_off_i(req_vaddr_off_i),
        .shf_valid_o(shf_valid_o), .shf_ready_i(shf_ready_i), .shf_req_id_o(shf_req_id_o),
        .shf_mode_o(shf_mode_o), .shf_eew_o(shf_eew_o), .shf_vd_o(shf_vd_o),
        .shf_vstart_o(shf_vstart_o), .shf_vm_o(shf_vm_o), .shf_vaddr_set_o(shf_vaddr_set_o),
        .shf_vaddr_off_o(shf_vaddr_off_o), .shf_cmt_cnt_o(shf_cmt_cnt_o),
        .lane_fire_i(lane_fire_i), .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
        .done_req_id_o(done_req_id_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic send(input logic [ReqIdBits-1:0] id, input logic [BW-1:0] nb);
        int k = 0;
        req_valid_i = 1'b1;
        req_id_i = id;
        req_mode_i = id[1:0];
        req_eew_i = id[3:2];
        req_vd_i = {1'b0, id};
        req_vstart_i = 16'h0100 + 16'(id);
        req_vm_i = id[0];
        req_vaddr_set_i = {2'b00, id};
        req_vaddr_off_i = ~id[1:0];
        req_nr_beats_i = nb;
        #1;
        while (!req_ready_o && k < 50) begin
            tick();
            k++;
        end
        if (k == 50) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: id %0d never accepted, required acceptance", id);
        end else exp_q.push_back(id);
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic fire(input logic [NrLanes-1:0] m);
        lane_fire_i = m;
        tick();
        lane_fire_i = '0;
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || done_valid_o) && k < 30) begin
            tick();
            k++;
        end
        if (k == 30) begin
            checks++;
            errors++;
            $error("FAIL drain_timeout: %0d dones still pending, required 0", exp_q.size());
        end
        settle();
        chk("busy_after_drain", 32'(busy_o), 32'd0);
    endtask

    // scoreboard: every done handshake must deliver the oldest expected id
    always @(negedge clk_i) begin
        if (!rst_i && done_valid_o && done_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL done_unexpected: observed id %0d, required no done", done_req_id_o);
            end else chk("done_id", 32'(done_req_id_o), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $error("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        rst_i = 1'b0;
        settle();
        chk("rst_shf_valid", 32'(shf_valid_o), 32'd0);
        chk("rst_done_valid", 32'(done_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_req_ready", 32'(req_ready_o), 32'd1);
        chk("rst_shf_id", 32'(shf_req_id_o), 32'd0);
        chk("rst_done_id", 32'(done_req_id_o), 32'd0);

        // single request, two beats on all lanes
        send(4'd3, 7'd2);
        settle();
        chk("t1_shf_valid", 32'(shf_valid_o), 32'd1);
        chk("t1_shf_id", 32'(shf_req_id_o), 32'd3);
        chk("t1_cmt_cnt", 32'(shf_cmt_cnt_o), 32'd1);
        chk("t1_vstart", 32'(shf_vstart_o), 32'h103);
        chk("t1_busy", 32'(busy_o), 32'd1);
        fire(4'hF);
        fire(4'hF);
        settle();
        chk("t1_done_not_yet", 32'(done_valid_o), 32'd0);
        tick();
        settle();
        chk("t1_done_valid", 32'(done_valid_o), 32'd1);
        chk("t1_done_id", 32'(done_req_id_o), 32'd3);
        tick();
        settle();
        chk("t1_done_clear", 32'(done_valid_o), 32'd0);
        chk("t1_busy_clear", 32'(busy_o), 32'd0);

        // skewed lanes: lane 0 runs into the second request
        send(4'd1, 7'd1);
        send(4'd2, 7'd1);
        fire(4'b0001);
        fire(4'b0001);
        settle();
        chk("t2_no_done", 32'(done_valid_o), 32'd0);
        fire(4'b1110);
        fire(4'b1110);
        settle();
        chk("t2_done1_valid", 32'(done_valid_o), 32'd1);
        chk("t2_done1_id", 32'(done_req_id_o), 32'd1);
        tick();
        settle();
        chk("t2_done2_valid", 32'(done_valid_o), 32'd1);
        chk("t2_done2_id", 32'(done_req_id_o), 32'd2);
        tick();
        settle();
        chk("t2_done_clear", 32'(done_valid_o), 32'd0);

        // completion coincides with a beat for the next request
        send(4'd6, 7'd1);
        send(4'd7, 7'd2);
        fire(4'hF);
        fire(4'hF);
        fire(4'hF);
        settle();
        chk("t3_no_early_done", 32'(done_valid_o), 32'd0);
        tick();
        settle();
        chk("t3_done_valid", 32'(done_valid_o), 32'd1);
        chk("t3_done_id", 32'(done_req_id_o), 32'd7);
        drain();

        // outstanding queue full
        send(4'd8, 7'd1);
        send(4'd9, 7'd1);
        send(4'd10, 7'd1);
        send(4'd11, 7'd1);
        req_valid_i = 1'b1;
        req_id_i = 4'd12;
        settle();
        chk("t4_full_ready", 32'(req_ready_o), 32'd0);
        tick();
        settle();
        chk("t4_full_ready_hold", 32'(req_ready_o), 32'd0);
        req_valid_i = 1'b0;
        fire(4'hF);
        settle();
        chk("t4_ready_before_pop", 32'(req_ready_o), 32'd0);
        fire(4'hF);
        settle();
        chk("t4_ready_after_pop", 32'(req_ready_o), 32'd1);
        fire(4'hF);
        fire(4'hF);
        drain();

        // shuffle backpressure holds the issue register
        shf_ready_i = 1'b0;
        send(4'd12, 7'd3);
        settle();
        chk("t5_shf_valid", 32'(shf_valid_o), 32'd1);
        chk("t5_mode", 32'(shf_mode_o), 32'd0);
        chk("t5_eew", 32'(shf_eew_o), 32'd3);
        chk("t5_vm", 32'(shf_vm_o), 32'd0);
        chk("t5_set", 32'(shf_vaddr_set_o), 32'd12);
        chk("t5_off", 32'(shf_vaddr_off_o), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("t5_hold_id", 32'(shf_req_id_o), 32'd12);
            chk("t5_hold_cmt", 32'(shf_cmt_cnt_o), 32'd2);
            chk("t5_hold_vd", 32'(shf_vd_o), 32'd12);
            chk("t5_hold_ready", 32'(req_ready_o), 32'd0);
            tick();
            settle();
        end
        shf_ready_i = 1'b1;
        send(4'd13, 7'd1);

        // done backpressure with two requests complete
        done_ready_i = 1'b0;
        fire(4'hF);
        fire(4'hF);
        fire(4'hF);
        fire(4'hF);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t6_hold_valid", 32'(done_valid_o), 32'd1);
            chk("t6_hold_id", 32'(done_req_id_o), 32'd12);
            tick();
        end
        done_ready_i = 1'b1;
        settle();
        chk("t6_first_id", 32'(done_req_id_o), 32'd12);
        tick();
        settle();
        chk("t6_second_valid", 32'(done_valid_o), 32'd1);
        chk("t6_second_id", 32'(done_req_id_o), 32'd13);
        drain();

        // reset with two requests outstanding
        send(4'd14, 7'd1);
        send(4'd15, 7'd1);
        settle();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        exp_q.delete();
        settle();
        chk("t7_shf_valid", 32'(shf_valid_o), 32'd0);
        chk("t7_done_valid", 32'(done_valid_o), 32'd0);
        chk("t7_busy", 32'(busy_o), 32'd0);
        chk("t7_ready", 32'(req_ready_o), 32'd1);
        chk("t7_shf_id", 32'(shf_req_id_o), 32'd0);
        chk("t7_cmt_cnt", 32'(shf_cmt_cnt_o), 32'd0);
        chk("t7_done_id", 32'(done_req_id_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            settle();
            chk("t7_no_done", 32'(done_valid_o), 32'd0);
        end
        send(4'd9, 7'd2);
        fire(4'hF);
        fire(4'hF);
        drain();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
